// File: rtl/mem_responder.sv
// Byte-wide memory responder: on-chip RAM plus a small IO window that is backed by
// TX/RX FIFOs toward the host link. Read data is registered, one cycle after the address.
module mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_WIDTH = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        program_finish
);

  localparam int DEPTH = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0]   CNT_FULL      = {1'b1, {FIFO_WIDTH{1'b0}}};
  localparam logic [FIFO_WIDTH:0]   CNT_NEAR_FULL = {1'b0, {FIFO_WIDTH{1'b1}}};
  localparam logic [FIFO_WIDTH:0]   CNT_ONE       = {{FIFO_WIDTH{1'b0}}, 1'b1};
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE       = {{(FIFO_WIDTH-1){1'b0}}, 1'b1};

  logic [7:0] ram [0:(1 << ADDR_WIDTH)-1];

  logic [ADDR_WIDTH-1:0] ram_index;
  logic                  is_io;
  logic [2:0]            io_offset;
  logic                  cpu_read;
  logic                  cpu_write;
  logic                  unused_addr_bits;

  logic [7:0]            tx_mem [0:DEPTH-1];
  logic [FIFO_WIDTH-1:0] tx_wr_ptr;
  logic [FIFO_WIDTH-1:0] tx_rd_ptr;
  logic [FIFO_WIDTH:0]   tx_count;
  logic [FIFO_WIDTH:0]   tx_count_next;
  logic                  tx_full;
  logic                  tx_push;
  logic                  tx_pop;

  logic [7:0]            rx_mem [0:DEPTH-1];
  logic [FIFO_WIDTH-1:0] rx_wr_ptr;
  logic [FIFO_WIDTH-1:0] rx_rd_ptr;
  logic [FIFO_WIDTH:0]   rx_count;
  logic [FIFO_WIDTH:0]   rx_count_next;
  logic                  rx_nonempty;
  logic                  rx_push;
  logic                  rx_pop;

  logic [7:0]            io_read_data;

  assign ram_index        = mem_a[ADDR_WIDTH-1:0];
  assign is_io            = (mem_a[17:16] == 2'b11);
  assign io_offset        = mem_a[2:0];
  assign cpu_read         = rdy_in & ~mem_wr;
  assign cpu_write        = rdy_in & mem_wr;
  assign unused_addr_bits = ^mem_a[31:18];

  assign tx_full     = (tx_count == CNT_FULL);
  assign tx_valid    = (tx_count != '0);
  assign tx_data     = tx_mem[tx_rd_ptr];
  assign tx_pop      = tx_valid & tx_ready;
  // A store into a full TX FIFO still lands if the host drains a byte in the same cycle.
  assign tx_push     = cpu_write & is_io & (io_offset == 3'd0) & (~tx_full | tx_pop);

  assign rx_nonempty = (rx_count != '0);
  assign rx_ready    = (rx_count != CNT_FULL);
  assign rx_pop      = cpu_read & is_io & (io_offset == 3'd0) & rx_nonempty;
  // While full, a host byte is still taken when the CPU frees a slot in that same cycle.
  assign rx_push     = rx_valid & (rx_ready | rx_pop);

  always_ff @(posedge clk_in) begin
    if (cpu_write && !is_io) begin
      ram[ram_index] <= mem_dout;
    end
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= mem_dout;
    end
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= rx_data;
    end
  end

  always_comb begin
    tx_count_next = tx_count;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_next = tx_count + CNT_ONE;
      2'b01:   tx_count_next = tx_count - CNT_ONE;
      default: tx_count_next = tx_count;
    endcase
  end

  always_comb begin
    rx_count_next = rx_count;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_next = rx_count + CNT_ONE;
      2'b01:   rx_count_next = rx_count - CNT_ONE;
      default: rx_count_next = rx_count;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      tx_count       <= '0;
      rx_wr_ptr      <= '0;
      rx_rd_ptr      <= '0;
      rx_count       <= '0;
      io_buffer_full <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      tx_count       <= tx_count_next;
      rx_count       <= rx_count_next;
      // One slot of slack covers the store already in flight when initiators see this.
      io_buffer_full <= (tx_count_next >= CNT_NEAR_FULL);
    end
  end

  always_comb begin
    io_read_data = 8'h00;
    case (io_offset)
      3'd0: begin
        if (rx_nonempty) begin
          io_read_data = rx_mem[rx_rd_ptr];
        end
      end
      3'd4:    io_read_data = {6'b0, rx_nonempty, tx_full};
      default: io_read_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din        <= 8'h00;
      program_finish <= 1'b0;
    end else begin
      if (cpu_read) begin
        mem_din <= is_io ? io_read_data : ram[ram_index];
      end
      program_finish <= cpu_write & is_io & (io_offset == 3'd4);
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against a queue/array reference model.
module tb_mem_responder;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        program_finish;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_ram [int];
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic [7:0] exp_din;
  bit         din_known;
  bit         exp_iobf;
  bit         exp_pf;

  mem_responder #(.ADDR_WIDTH(17), .FIFO_WIDTH(3)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .program_finish (program_finish)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    tx_q.delete();
    rx_q.delete();
    exp_din   = 8'h00;
    din_known = 1'b1;
    exp_iobf  = 1'b0;
    exp_pf    = 1'b0;
  endtask

  task automatic checkState();
    if (din_known) checkOutput("mem_din", 32'(mem_din), 32'(exp_din));
    checkOutput("io_buffer_full", 32'(io_buffer_full), 32'(exp_iobf));
    checkOutput("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
    if (tx_q.size() != 0) checkOutput("tx_data", 32'(tx_data), 32'(tx_q[0]));
    checkOutput("rx_ready", 32'(rx_ready), 32'(rx_q.size() != 8));
    checkOutput("program_finish", 32'(program_finish), 32'(exp_pf));
  endtask

  // Drives one bus cycle from just after a rising edge, advances the model, then checks.
  task automatic applyStimulus(input logic rdy, input logic [31:0] a, input logic [7:0] d,
                               input logic wr, input logic txr, input logic rxv,
                               input logic [7:0] rxd);
    bit is_io;
    int idx;
    int off;
    bit do_tx_pop, do_rx_pop, do_rx_push, do_tx_push;
    rdy_in   = rdy;
    mem_a    = a;
    mem_dout = d;
    mem_wr   = wr;
    tx_ready = txr;
    rx_valid = rxv;
    rx_data  = rxd;
    is_io      = (a[17:16] == 2'b11);
    idx        = int'(a[16:0]);
    off        = int'(a[2:0]);
    do_tx_pop  = (tx_q.size() != 0) && txr;
    do_rx_pop  = rdy && !wr && is_io && off == 0 && rx_q.size() != 0;
    do_rx_push = rxv && (rx_q.size() != 8 || do_rx_pop);
    do_tx_push = rdy && wr && is_io && off == 0 && (tx_q.size() != 8 || do_tx_pop);
    if (rdy && !wr) begin
      din_known = 1'b1;
      if (!is_io) begin
        if (model_ram.exists(idx)) exp_din = model_ram[idx];
        else din_known = 1'b0;
      end else if (off == 0) begin
        exp_din = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      end else if (off == 4) begin
        exp_din = {6'b0, (rx_q.size() != 0), (tx_q.size() == 8)};
      end else begin
        exp_din = 8'h00;
      end
    end
    if (rdy && wr && !is_io) model_ram[idx] = d;
    exp_pf = rdy && wr && is_io && off == 4;
    if (do_tx_pop)  void'(tx_q.pop_front());
    if (do_tx_push) tx_q.push_back(d);
    if (do_rx_pop)  void'(rx_q.pop_front());
    if (do_rx_push) rx_q.push_back(rxd);
    exp_iobf = (tx_q.size() >= 7);
    @(posedge clk_in);
    #1;
    checkState();
  endtask

  task automatic idle(input logic txr);
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, txr, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] a;
    rst_in   = 1'b1;
    rdy_in   = 1'b0;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    modelReset();
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("reset_mem_din", 32'(mem_din), 32'h00);
    checkOutput("reset_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("reset_rx_ready", 32'(rx_ready), 32'h1);
    checkOutput("reset_iobf", 32'(io_buffer_full), 32'h0);
    checkOutput("reset_pf", 32'(program_finish), 32'h0);
    rst_in = 1'b0;

    // RAM write then read back next cycle
    applyStimulus(1'b1, 32'h10, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 32'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("ram_a5", 32'(mem_din), 32'hA5);

    // Aliasing on upper address bits, then rdy_in low blocks writes
    applyStimulus(1'b1, 32'h0002_0010, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 32'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("ram_alias", 32'(mem_din), 32'h11);
    repeat (3) applyStimulus(1'b0, 32'h10, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("rdy_hold", 32'(mem_din), 32'h11);
    applyStimulus(1'b1, 32'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rdy_no_write", 32'(mem_din), 32'h11);

    // Fill the TX FIFO with the host stalled
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h0003_0000, 8'(8'h41 + i), 1'b1, 1'b0, 1'b0, 8'h00);
      if (i == 5) checkOutput("iobf_after6", 32'(io_buffer_full), 32'h0);
      if (i == 6) checkOutput("iobf_after7", 32'(io_buffer_full), 32'h1);
    end
    checkOutput("tx_head", 32'(tx_data), 32'h41);
    applyStimulus(1'b1, 32'h0003_0000, 8'h49, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      checkOutput("tx_order", 32'(tx_data), 32'(8'h41 + i));
      idle(1'b1);
    end
    checkOutput("tx_drained", 32'(tx_valid), 32'h0);
    checkOutput("iobf_drained", 32'(io_buffer_full), 32'h0);

    // RX status and pops, including an empty read
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h30);
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h31);
    applyStimulus(1'b1, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rx_status", 32'(mem_din), 32'h02);
    applyStimulus(1'b1, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rx_pop0", 32'(mem_din), 32'h30);
    applyStimulus(1'b1, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rx_pop1", 32'(mem_din), 32'h31);
    applyStimulus(1'b1, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rx_empty", 32'(mem_din), 32'h00);
    applyStimulus(1'b1, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rx_status_empty", 32'(mem_din), 32'h00);

    // Full RX FIFO with simultaneous CPU pop and host push
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1, 8'(8'h50 + i));
    checkOutput("rx_full", 32'(rx_ready), 32'h0);
    applyStimulus(1'b1, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h58);
    checkOutput("rx_full_pop", 32'(mem_din), 32'h50);
    checkOutput("rx_still_full", 32'(rx_ready), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("rx_order", 32'(mem_din), 32'(8'h50 + i));
    end
    applyStimulus(1'b1, 32'h0003_0004, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("pf_high", 32'(program_finish), 32'h1);
    idle(1'b0);
    checkOutput("pf_low", 32'(program_finish), 32'h0);

    // Asynchronous reset in the middle of a TX drain
    applyStimulus(1'b1, 32'h20, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h0003_0000, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0, 8'h00);
    idle(1'b1);
    #3;
    rst_in = 1'b1;
    #1;
    checkOutput("async_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("async_mem_din", 32'(mem_din), 32'h00);
    checkOutput("async_rx_ready", 32'(rx_ready), 32'h1);
    modelReset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    idle(1'b0);
    applyStimulus(1'b1, 32'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("ram_retained", 32'(mem_din), 32'h5A);
    applyStimulus(1'b1, 32'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("ram_retained2", 32'(mem_din), 32'h11);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    a = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 15));
        2:       a = 32'h0003_0000;
        3:       a = 32'h0003_0004;
        4:       a = 32'h0003_0000 | 32'($urandom_range(0, 7));
        5:       a = ($urandom & 32'hFFFC_0007) | 32'h0003_0000;
        default: a = ($urandom & 32'hFFFD_0000) | 32'($urandom_range(0, 15));
      endcase
      applyStimulus($urandom_range(0, 9) < 8, a, 8'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
